// File: rtl/apb3_pkg.sv
// Shared types and helpers for the APB3 register-array completer.
// The FSM state enum, the wait counter width and the lane/shift helpers
// that turn a data width into byte-lane count and word-index shift.
package apb3_pkg;

    // Transfer FSM: IDLE waits for a setup phase, WAIT burns the
    // programmed wait states, DONE holds pready until the access completes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb3_state_e;

    // Wait-state counter width (0..15 wait states).
    localparam int unsigned CNT_W = 4;

    // Number of byte lanes in a data word.
    function automatic int unsigned lanes_of(input int unsigned width);
        return width / 8;
    endfunction

    // Right shift that turns a byte address into a word index.
    function automatic int unsigned idx_shift_of(input int unsigned width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/apb3_wait_ctr.sv
// Loadable 4-bit down-counter used by the APB FSM to time wait states.
// done_o flags value == 1, i.e. the next decrement ends the wait.
module apb3_wait_ctr
    import apb3_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign done_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb3_slave_mem.sv
// APB3 completer backed by a DEPTH x WIDTH register array.
// Programmable wait states, PSLVERR on misaligned or out-of-range access.
// Optional byte strobes: define APB_PSTRB_EN to add pstrb_i (APB4 style).
//
// Handshake: a transfer starts with a setup edge (psel_i=1, penable_i=0)
// seen in IDLE; it completes on the edge where psel_i, penable_i and
// pready_o are all 1. Dropping psel_i before that aborts without effect.
// prdata_o / pslverr_o are only meaningful while pready_o=1.
//
// Parameter limits: WIDTH in {8,16,32,64}, WAIT_STATES in 0..15,
// DEPTH*(WIDTH/8) <= 2**ADDR_WIDTH.
module apb3_slave_mem
    import apb3_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [WIDTH-1:0]      pwdata_i,
`ifdef APB_PSTRB_EN
    input  logic [WIDTH/8-1:0]    pstrb_i,
`endif
    output logic [WIDTH-1:0]      prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output apb3_state_e           dbg_state_o
);

    localparam int unsigned LANES  = lanes_of(WIDTH);
    localparam int unsigned SHIFT  = idx_shift_of(WIDTH);
    localparam int unsigned IDX_W  = ADDR_WIDTH - SHIFT;
    localparam int unsigned MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << SHIFT) - 1);
    localparam logic [IDX_W:0]        DEPTH_L    = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]      WS_L       = CNT_W'(WAIT_STATES);

    // Request captured at the setup edge and held for the whole transfer.
    // The word index is stored instead of the byte address; the address
    // is fully decoded into widx/err at capture.
    typedef struct packed {
        logic [MIDX_W-1:0] widx;
        logic              write;
        logic [WIDTH-1:0]  wdata;
        logic              err;
        logic [LANES-1:0]  strb;
    } req_t;

    apb3_state_e      state_d, state_q;
    req_t             req_d, req_q;
    logic             pready_d, pready_q;
    logic             pslverr_d, pslverr_q;
    logic [WIDTH-1:0] prdata_d, prdata_q;
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0] full_idx;
    logic             misaligned;
    logic             oob;
    logic [LANES-1:0] strb_in;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_value;
    logic             enter_done;
    logic             wr_commit;

    // Address decode of the live bus address (only used at setup).
    always_comb begin
        full_idx   = paddr_i[ADDR_WIDTH-1:SHIFT];
        misaligned = ((paddr_i & ALIGN_MASK) != '0);
        oob        = ({1'b0, full_idx} >= DEPTH_L);
`ifdef APB_PSTRB_EN
        strb_in    = pstrb_i;
`else
        strb_in    = '1;
`endif
    end

    apb3_wait_ctr u_wait_ctr (
        .clk_i      (pclk_i),
        .rst_i      (preset_i),
        .load_i     (cnt_load),
        .load_val_i (WS_L),
        .dec_i      (cnt_dec),
        .value_o    (cnt_value),
        .done_o     (cnt_done)
    );

    // FSM next state, request capture and registered bus outputs.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        enter_done = 1'b0;
        wr_commit  = 1'b0;

        case (state_q)
            IDLE: begin
                // psel_i & penable_i without a prior setup is not a transfer.
                if (psel_i && !penable_i) begin
                    req_d.widx  = full_idx[MIDX_W-1:0];
                    req_d.write = pwrite_i;
                    req_d.wdata = pwdata_i;
                    req_d.err   = misaligned | oob;
                    req_d.strb  = strb_in;
                    cnt_load    = 1'b1;
                    if (WS_L == '0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_done) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!psel_i) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (penable_i) begin
                    wr_commit = req_q.write & ~req_q.err;
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase

        // Response is registered on the edge that enters DONE; req_d is
        // the request in force whether it was captured now or earlier.
        if (enter_done) begin
            pready_d  = 1'b1;
            pslverr_d = req_d.err;
            prdata_d  = (req_d.write || req_d.err) ? '0 : mem_q[req_d.widx];
        end
    end

    // Memory write on completion, honouring the captured byte strobes.
    always_comb begin
        mem_d = mem_q;
        if (wr_commit) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (req_q.strb[b]) begin
                    mem_d[req_q.widx][8*b +: 8] = req_q.wdata[8*b +: 8];
                end
            end
        end
    end

    // Control and response registers; reset abandons any transfer.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Register array, cleared by reset.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign prdata_o    = prdata_q;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb3_slave_mem.sv
// Self-checking bench for apb3_slave_mem (ADDR_WIDTH=8, WIDTH=32, DEPTH=16,
// WAIT_STATES=2): directed vector table, multi-cycle corner sequences and
// randomized transfers against a word-array reference model.
module tb_apb3_slave_mem;
    import apb3_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int WS = 2;
    localparam int MAX_WAIT = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    apb3_state_e   dbg_state;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
    } vec_t;

    vec_t vecs [15];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    apb3_slave_mem #(
        .ADDR_WIDTH  (AW),
        .WIDTH       (DW),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .pclk_i      (clk),
        .preset_i    (rst),
        .psel_i      (psel),
        .penable_i   (penable),
        .pwrite_i    (pwrite),
        .paddr_i     (paddr),
        .pwdata_i    (pwdata),
`ifdef APB_PSTRB_EN
        .pstrb_i     (pstrb),
`endif
        .prdata_o    (prdata),
        .pready_o    (pready),
        .pslverr_o   (pslverr),
        .dbg_state_o (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_err(input logic [AW-1:0] a);
        return (a % 4 != 0) || (int'(a) / 4 >= DEPTH);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_err(a)) return '0;
        return model_mem[int'(a) / 4];
    endfunction

    function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [3:0] s);
        logic [3:0] eff;
        int w;
`ifdef APB_PSTRB_EN
        eff = s;
`else
        eff = 4'hF;
`endif
        if (ref_err(a)) return;
        w = int'(a) / 4;
        for (int b = 0; b < 4; b++) begin
            if (eff[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input string name, output int waits);
        waits = 0;
        while (pready !== 1'b1 && waits < MAX_WAIT) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (pready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: pready still %b after %0d cycles, required 1", name, pready, waits);
        end
    endtask

    // One full transfer. Request fields are scrambled during the access
    // phase to make sure the completer uses what it captured at setup.
    task automatic apb_xfer(input string name, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] s,
                            output logic [DW-1:0] rdata, output logic err, output int waits);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        @(posedge clk);
        #1;
        penable = 1'b1;
        paddr   = AW'($urandom);
        pwdata  = $urandom;
        pwrite  = ~wr;
        pstrb   = 4'($urandom);
        wait_ready(name, waits);
        rdata = prdata;
        err   = pslverr;
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        check({name, "_ready_drop"}, DW'(pready), '0);
    endtask

    // Transfer checked against the reference model.
    task automatic do_xfer(input string name, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] s);
        logic [DW-1:0] rdata;
        logic          err;
        int            waits;
        bit            exp_err;
        exp_err = ref_err(a);
        exp_q.push_back(wr ? '0 : ref_read(a));
        apb_xfer(name, wr, a, d, s, rdata, err, waits);
        check({name, "_rdata"}, rdata, exp_q.pop_front());
        check({name, "_err"}, DW'(err), DW'(exp_err));
        check({name, "_waits"}, DW'(waits), DW'(WS));
        if (wr) ref_write(a, d, s);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [DW-1:0] rdata;
        logic          err;
        int            waits;
        int            hi_cnt;

        vecs[0]  = '{1'b1, 8'h08, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 8'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 8'h40, 32'h0,        32'h0,        1'b1};
        vecs[3]  = '{1'b1, 8'h40, 32'h55AA55AA, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 8'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 8'h04, 32'h12345678, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 8'h06, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 8'h04, 32'h0,        32'h12345678, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 32'h00000011, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 8'h00, 32'h0,        32'h00000011, 1'b0};
        vecs[10] = '{1'b0, 8'h3C, 32'h0,        32'h0,        1'b0};
        vecs[11] = '{1'b1, 8'h3C, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 8'h3C, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b0, 8'hFF, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b0, 8'h3D, 32'h0,        32'h0,        1'b1};

        rst = 1'b1;
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;
        pstrb = 4'hF;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", DW'(pready), '0);
        check("rst_pslverr", DW'(pslverr), '0);
        check("rst_prdata", prdata, '0);
        check("rst_state", DW'(dbg_state), DW'(IDLE));
        rst = 1'b0;
        idle_cycles(1);

        // Directed table, issued back-to-back (next setup right after completion).
        for (int i = 0; i < 15; i++) begin
            apb_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF,
                     rdata, err, waits);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), DW'(err), DW'(vecs[i].exp_err));
            check($sformatf("vec%0d_waits", i), DW'(waits), DW'(WS));
            if (vecs[i].wr) ref_write(vecs[i].addr, vecs[i].wdata, 4'hF);
        end
        for (int w = 0; w < DEPTH; w++) begin
            do_xfer($sformatf("dump%0d", w), 1'b0, AW'(w * 4), '0, 4'hF);
        end

        // psel & penable in IDLE without a setup phase must not start a transfer.
        idle_cycles(1);
        psel = 1'b1;
        penable = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle_cycles(1);
            if (pready === 1'b1) hi_cnt++;
        end
        psel = 1'b0;
        penable = 1'b0;
        check("nosetup_ready", DW'(hi_cnt), '0);
        idle_cycles(1);

        // Abort during WAIT: no write, no response.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h77777777;
        idle_cycles(1);
        penable = 1'b1;
        idle_cycles(1);
        psel = 1'b0; penable = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle_cycles(1);
            if (pready === 1'b1 || pslverr === 1'b1) hi_cnt++;
        end
        check("abort_wait_resp", DW'(hi_cnt), '0);
        check("abort_wait_state", DW'(dbg_state), DW'(IDLE));
        do_xfer("abort_wait_rd", 1'b0, 8'h10, '0, 4'hF);

        // Abort during DONE: pready drops, memory untouched.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'h99999999;
        idle_cycles(1);
        penable = 1'b1;
        wait_ready("abort_done", waits);
        psel = 1'b0; penable = 1'b0;
        idle_cycles(1);
        check("abort_done_ready", DW'(pready), '0);
        do_xfer("abort_done_rd", 1'b0, 8'h14, '0, 4'hF);

        // Reset in WAIT of a write: outputs clear, write not committed, memory cleared.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h00000055;
        idle_cycles(1);
        penable = 1'b1;
        idle_cycles(1);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        psel = 1'b0; penable = 1'b0;
        ref_reset();
        check("rstwait_pready", DW'(pready), '0);
        check("rstwait_pslverr", DW'(pslverr), '0);
        check("rstwait_prdata", prdata, '0);
        do_xfer("rstwait_rd0c", 1'b0, 8'h0C, '0, 4'hF);
        do_xfer("rstwait_rd08", 1'b0, 8'h08, '0, 4'hF);

        // Reset while a read response is being held.
        do_xfer("rstdone_wr", 1'b1, 8'h20, 32'hA5A5A5A5, 4'hF);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h20;
        idle_cycles(1);
        penable = 1'b1;
        wait_ready("rstdone", waits);
        check("rstdone_pre", prdata, 32'hA5A5A5A5);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        psel = 1'b0; penable = 1'b0;
        ref_reset();
        check("rstdone_pready", DW'(pready), '0);
        check("rstdone_prdata", prdata, '0);
        do_xfer("rstdone_rd", 1'b0, 8'h20, '0, 4'hF);

`ifdef APB_PSTRB_EN
        do_xfer("strb_wr_full", 1'b1, 8'h00, 32'hAABBCCDD, 4'hF);
        do_xfer("strb_wr_part", 1'b1, 8'h00, 32'h11223344, 4'b0101);
        apb_xfer("strb_rd", 1'b0, 8'h00, '0, 4'hF, rdata, err, waits);
        check("strb_rd_rdata", rdata, 32'hAA22CC44);
        do_xfer("strb_wr_none", 1'b1, 8'h00, 32'hFFFFFFFF, 4'b0000);
        do_xfer("strb_rd_after_none", 1'b0, 8'h00, '0, 4'hF);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 8'h47));
            if ($urandom_range(0, 3) != 0) a = a & 8'hFC;
            do_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                    4'($urandom));
            idle_cycles($urandom_range(0, 2));
        end
        for (int w = 0; w < DEPTH; w++) begin
            do_xfer($sformatf("final%0d", w), 1'b0, AW'(w * 4), '0, 4'hF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
